// File: rtl/bus_demultiplexer_2_if.sv
// Bus bundle for the buffered 1-to-2 demultiplexer: one producer-side input
// port and two consumer-side output channels, each with valid/ready.
interface bus_demultiplexer_2_if #(
    parameter int NrOfBits = 1
);
    logic [NrOfBits-1:0] DemuxIn;
    logic                DemuxIn_Valid;
    logic                DemuxIn_Ready;
    logic                Sel;

    logic [NrOfBits-1:0] DemuxOut_0;
    logic                DemuxOut_0_Valid;
    logic                DemuxOut_0_Ready;

    logic [NrOfBits-1:0] DemuxOut_1;
    logic                DemuxOut_1_Valid;
    logic                DemuxOut_1_Ready;

    // Environment side: drives the input word and the consumer readies.
    modport master (
        output DemuxIn, DemuxIn_Valid, Sel, DemuxOut_0_Ready, DemuxOut_1_Ready,
        input  DemuxIn_Ready, DemuxOut_0, DemuxOut_0_Valid, DemuxOut_1, DemuxOut_1_Valid
    );

    // Demultiplexer side.
    modport slave (
        input  DemuxIn, DemuxIn_Valid, Sel, DemuxOut_0_Ready, DemuxOut_1_Ready,
        output DemuxIn_Ready, DemuxOut_0, DemuxOut_0_Valid, DemuxOut_1, DemuxOut_1_Valid
    );
endinterface

// File: rtl/bus_demultiplexer_2.sv
// Buffered 1-to-2 bus demultiplexer with a 2-entry FIFO per output channel.
// Optional macro DEMUX_BYPASS_EN adds a 0-cycle path into an empty, ready channel.
module bus_demultiplexer_2 #(
    parameter int NrOfBits = 1
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Enable,
    bus_demultiplexer_2_if.slave  bus
);

    logic [1:0]          count      [2];
    logic                push       [2];
    logic                out_ready  [2];
    logic                out_valid  [2];
    logic [NrOfBits-1:0] out_data   [2];
    logic [1:0]          sel_count;
    logic                in_ready;

    // Fullness check uses the registered count only, so there is no
    // combinational path from a consumer's ready back to DemuxIn_Ready.
    assign sel_count = bus.Sel ? count[1] : count[0];
    assign in_ready  = Enable & (sel_count < 2'd2);

    assign bus.DemuxIn_Ready    = in_ready;
    assign out_ready[0]         = bus.DemuxOut_0_Ready;
    assign out_ready[1]         = bus.DemuxOut_1_Ready;
    assign bus.DemuxOut_0       = out_data[0];
    assign bus.DemuxOut_0_Valid = out_valid[0];
    assign bus.DemuxOut_1       = out_data[1];
    assign bus.DemuxOut_1_Valid = out_valid[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [NrOfBits-1:0] mem_q [2];
            logic [1:0]          count_q, count_d;
            logic                wr_ptr_q, wr_ptr_d;
            logic                rd_ptr_q, rd_ptr_d;
            logic                selected;
            logic                stored_valid;
            logic                bypass;
            logic                pop;
            logic [NrOfBits-1:0] head;

            assign selected     = (gi == 1) ? bus.Sel : ~bus.Sel;
            assign stored_valid = Enable & (count_q != 2'd0);
            assign head         = mem_q[rd_ptr_q];

`ifdef DEMUX_BYPASS_EN
            // Empty channel with a ready consumer: hand the word straight through.
            assign bypass = Enable & bus.DemuxIn_Valid & selected &
                            (count_q == 2'd0) & out_ready[gi];
`else
            assign bypass = 1'b0;
`endif

            assign push[gi]  = bus.DemuxIn_Valid & in_ready & selected & ~bypass;
            assign pop       = stored_valid & out_ready[gi];
            assign count[gi] = count_q;

            always_comb begin
                count_d  = count_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (push[gi]) wr_ptr_d = ~wr_ptr_q;
                if (pop)      rd_ptr_d = ~rd_ptr_q;
                case ({push[gi], pop})
                    2'b10:   count_d = count_q + 2'd1;
                    2'b01:   count_d = count_q - 2'd1;
                    default: count_d = count_q;
                endcase
            end

            always_comb begin
                out_valid[gi] = stored_valid | bypass;
                out_data[gi]  = '0;
                if (stored_valid)
                    out_data[gi] = head;
                else if (bypass)
                    out_data[gi] = bus.DemuxIn;
            end

            always_ff @(posedge Clock or negedge Reset_n) begin
                if (!Reset_n) begin
                    count_q  <= 2'd0;
                    wr_ptr_q <= 1'b0;
                    rd_ptr_q <= 1'b0;
                end else begin
                    count_q  <= count_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            // Storage needs no reset: a zero count masks stale entries.
            always_ff @(posedge Clock) begin
                if (push[gi])
                    mem_q[wr_ptr_q] <= bus.DemuxIn;
            end
        end
    endgenerate

endmodule

// File: tb/tb_bus_demultiplexer_2.sv
// Directed-step bench for bus_demultiplexer_2 with a per-channel scoreboard.
module tb_bus_demultiplexer_2;
    localparam int W = 8;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic en     = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb0[$];
    logic [W-1:0] sb1[$];

    bus_demultiplexer_2_if #(.NrOfBits(W)) bus ();

    bus_demultiplexer_2 #(.NrOfBits(W)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .Enable  (en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, score just before the rising edge.
    task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                        input logic r0, input logic r1, input logic e);
        logic         exp_rdy, exp_v0, exp_v1;
        logic [W-1:0] exp_d0, exp_d1;
        @(negedge clk);
        bus.DemuxIn_Valid    = v;
        bus.Sel              = s;
        bus.DemuxIn          = d;
        bus.DemuxOut_0_Ready = r0;
        bus.DemuxOut_1_Ready = r1;
        en                   = e;
        #4;
        exp_rdy = e & ((s ? sb1.size() : sb0.size()) < 2);
        exp_v0  = e & (sb0.size() != 0);
        exp_v1  = e & (sb1.size() != 0);
`ifdef DEMUX_BYPASS_EN
        if (e & v & !s & r0 & (sb0.size() == 0)) exp_v0 = 1'b1;
        if (e & v &  s & r1 & (sb1.size() == 0)) exp_v1 = 1'b1;
`endif
        chk("in_ready", bus.DemuxIn_Ready, exp_rdy);
        chk("valid0", bus.DemuxOut_0_Valid, exp_v0);
        chk("valid1", bus.DemuxOut_1_Valid, exp_v1);
        if (v & exp_rdy) begin
            if (s) sb1.push_back(d);
            else   sb0.push_back(d);
        end
        exp_d0 = exp_v0 ? sb0[0] : '0;
        exp_d1 = exp_v1 ? sb1[0] : '0;
        chk("data0", bus.DemuxOut_0, exp_d0);
        chk("data1", bus.DemuxOut_1, exp_d1);
        if (exp_v0 & r0) void'(sb0.pop_front());
        if (exp_v1 & r1) void'(sb1.pop_front());
        $display("step v=%0b sel=%0b din=%02h r0=%0b r1=%0b en=%0b | rdy=%0b o0=%0b/%02h o1=%0b/%02h",
                 v, s, d, r0, r1, e, bus.DemuxIn_Ready, bus.DemuxOut_0_Valid, bus.DemuxOut_0,
                 bus.DemuxOut_1_Valid, bus.DemuxOut_1);
    endtask

    initial begin
        bus.DemuxIn_Valid    = 1'b0;
        bus.Sel              = 1'b0;
        bus.DemuxIn          = '0;
        bus.DemuxOut_0_Ready = 1'b0;
        bus.DemuxOut_1_Ready = 1'b0;
        en                   = 1'b1;

        // Reset held for two cycles.
        #1;
        chk("rst_valid0", bus.DemuxOut_0_Valid, 1'b0);
        chk("rst_data0",  bus.DemuxOut_0, 8'h00);
        chk("rst_valid1", bus.DemuxOut_1_Valid, 1'b0);
        chk("rst_data1",  bus.DemuxOut_1, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("post_rst_ready", bus.DemuxIn_Ready, 1'b1);

        // Basic routing and 1-cycle latency.
        step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
`ifndef DEMUX_BYPASS_EN
        chk("a5_not_same_cycle", bus.DemuxOut_0_Valid, 1'b0);
`endif
        step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        chk("a5_latency_valid", bus.DemuxOut_0_Valid, 1'b1);
        chk("a5_latency_data",  bus.DemuxOut_0, 8'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
`ifndef DEMUX_BYPASS_EN
        chk("3c_latency_data",  bus.DemuxOut_1, 8'h3C);
        chk("3c_other_idle",    bus.DemuxOut_0_Valid, 1'b0);
`endif

        // Fill channel 0; channel 1 still accepts.
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1);
        chk("full0_blocks", bus.DemuxIn_Ready, 1'b0);
        step(1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1);
        chk("full0_ch1_ok", bus.DemuxIn_Ready, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1);
        chk("drain_11", bus.DemuxOut_0, 8'h11);
        step(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1);
        chk("drain_22", bus.DemuxOut_0, 8'h22);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("drain_33", bus.DemuxOut_0, 8'h33);

        // Simultaneous push/pop at count 1 across 8 transfers.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, 1'b1);
            chk("pp_head", bus.DemuxOut_0, 32'(i - 1));
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("pp_last", bus.DemuxOut_0, 8'h07);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

        // Enable low freezes everything.
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0);
            chk("frozen_ready", bus.DemuxIn_Ready, 1'b0);
            chk("frozen_data1", bus.DemuxOut_1, 8'h00);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("resume_55", bus.DemuxOut_1, 8'h55);

        // Asynchronous reset with words buffered.
        step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_valid0", bus.DemuxOut_0_Valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid0", bus.DemuxOut_0_Valid, 1'b0);
        chk("async_valid1", bus.DemuxOut_1_Valid, 1'b0);
        chk("async_data0",  bus.DemuxOut_0, 8'h00);
        sb0.delete();
        sb1.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

`ifdef DEMUX_BYPASS_EN
        // Bypass into an empty, ready channel.
        step(1'b1, 1'b0, 8'h9E, 1'b1, 1'b1, 1'b1);
        chk("byp_valid", bus.DemuxOut_0_Valid, 1'b1);
        chk("byp_data",  bus.DemuxOut_0, 8'h9E);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("byp_not_stored", bus.DemuxOut_0_Valid, 1'b0);
        step(1'b1, 1'b0, 8'h9E, 1'b0, 1'b1, 1'b1);
        chk("nobyp_valid", bus.DemuxOut_0_Valid, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("nobyp_next", bus.DemuxOut_0, 8'h9E);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
